// File: rtl/tlb_pkg.sv
// Shared types and constants for the ASID-tagged set-associative TLB.
package tlb_pkg;
  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 32 - PAGE_OFFSET_W;
  localparam int ASID_MAX_W    = 16;  // entries store ASIDs zero-extended to this width

  localparam int PTE_R = 0;
  localparam int PTE_W = 1;
  localparam int PTE_X = 2;
  localparam int PTE_G = 3;

  typedef enum logic [1:0] {ACC_READ, ACC_WRITE, ACC_EXEC, ACC_RSVD} access_type_t;
  typedef enum logic [1:0] {FL_ALL, FL_ASID, FL_PAGE, FL_NOP} flush_mode_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_LOOKUP   = 3'd1;
  localparam state_t S_PTW_REQ  = 3'd2;
  localparam state_t S_PTW_WAIT = 3'd3;
  localparam state_t S_FILL     = 3'd4;
  localparam state_t S_RESPOND  = 3'd5;
  localparam state_t S_FLUSH    = 3'd6;

  typedef struct packed {
    logic                  valid;
    logic [VPN_W-1:0]      vpn;
    logic [VPN_W-1:0]      ppn;
    logic [ASID_MAX_W-1:0] asid;
    logic                  g;
    logic                  x;
    logic                  w;
    logic                  r;
  } tlb_entry_t;

  function automatic logic perm_ok(access_type_t t, logic x, logic w, logic r);
    case (t)
      ACC_READ:  perm_ok = r;
      ACC_WRITE: perm_ok = w;
      ACC_EXEC:  perm_ok = x;
      default:   perm_ok = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/tlb_asid_if.sv
// Request/response, page-walker and flush channels of the TLB.
interface tlb_asid_if #(parameter int ASID_W = 8);
  logic              req_valid_i, req_ready_o;
  logic [31:0]       vaddr_i;
  logic [ASID_W-1:0] asid_i;
  logic [1:0]        access_type_i;
  logic              resp_valid_o, resp_ready_i;
  logic [31:0]       paddr_o;
  logic              hit_o, fault_o;
  logic              ptw_req_valid_o, ptw_req_ready_i;
  logic [31:0]       ptw_vaddr_o;
  logic              ptw_resp_valid_i, ptw_resp_ready_o;
  logic [31:0]       ptw_pte_i;
  logic              ptw_fault_i;
  logic              flush_valid_i, flush_ready_o;
  logic [1:0]        flush_mode_i;
  logic [31:0]       flush_vaddr_i;
  logic [ASID_W-1:0] flush_asid_i;

  modport slave (
    input  req_valid_i, vaddr_i, asid_i, access_type_i, resp_ready_i,
           ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i, ptw_fault_i,
           flush_valid_i, flush_mode_i, flush_vaddr_i, flush_asid_i,
    output req_ready_o, resp_valid_o, paddr_o, hit_o, fault_o,
           ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o, flush_ready_o
  );
  modport master (
    output req_valid_i, vaddr_i, asid_i, access_type_i, resp_ready_i,
           ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i, ptw_fault_i,
           flush_valid_i, flush_mode_i, flush_vaddr_i, flush_asid_i,
    input  req_ready_o, resp_valid_o, paddr_o, hit_o, fault_o,
           ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o, flush_ready_o
  );
endinterface

// File: rtl/tlb_lru.sv
// True-LRU age array for every set; age 0 is most recently used.
module tlb_lru #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic [NUM_WAYS-1:0] set_valid,
  input  logic                touch,
  input  logic [WAY_W-1:0]    touch_way,
  output logic [WAY_W-1:0]    victim
);
  logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < age[set_idx][touch_way])
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

  // Empty ways are filled first (lowest index), otherwise the oldest way goes.
  always_comb begin
    logic found;
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!set_valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    if (!found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age[set_idx][w] == WAY_W'(NUM_WAYS-1)) victim = WAY_W'(w);
  end
endmodule

// File: rtl/tlb_asid.sv
// ASID-tagged set-associative TLB with walker refill, flush port and true LRU.
// Optional TLB_PERF_CNT_EN adds hit/miss counters.
module tlb_asid import tlb_pkg::*; #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int ASID_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  tlb_asid_if.slave  bus
`ifdef TLB_PERF_CNT_EN
  ,
  input  logic        perf_clr_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  state_t            state;
  logic [31:0]       vaddr_q;
  logic [ASID_W-1:0] asid_q, fasid_q;
  access_type_t      acc_q;
  flush_mode_t       fmode_q;
  logic [VPN_W-1:0]  fvpn_q, pte_ppn_q;
  logic [IDX_W-1:0]  fset_q;
  logic [3:0]        pte_flags_q;
  logic              pfault_q;
  logic [31:0]       paddr_q;
  logic              hit_q, fault_q;
  tlb_entry_t        ent [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]      idx;
  logic [VPN_W-1:0]      vpn;
  logic [ASID_MAX_W-1:0] asid_ext, fasid_ext;
  logic [NUM_WAYS-1:0]   match, valid_vec, clr;
  logic [WAY_W-1:0]      hit_way, victim, touch_way;
  logic                  hit, hit_perm, fill_perm, touch;
  tlb_entry_t            hit_e;

  assign idx       = vaddr_q[PAGE_OFFSET_W +: IDX_W];
  assign vpn       = vaddr_q[31:PAGE_OFFSET_W];
  assign asid_ext  = ASID_MAX_W'(asid_q);
  assign fasid_ext = ASID_MAX_W'(fasid_q);

  always_comb begin
    match     = '0;
    valid_vec = '0;
    hit_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      valid_vec[w] = ent[idx][w].valid;
      match[w] = ent[idx][w].valid && ent[idx][w].vpn == vpn &&
                 (ent[idx][w].g || ent[idx][w].asid == asid_ext);
    end
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (match[w]) hit_way = WAY_W'(w);
  end

  assign hit       = |match;
  assign hit_e     = ent[idx][hit_way];
  assign hit_perm  = perm_ok(acc_q, hit_e.x, hit_e.w, hit_e.r);
  assign fill_perm = perm_ok(acc_q, pte_flags_q[PTE_X], pte_flags_q[PTE_W], pte_flags_q[PTE_R]);
  assign touch     = (state == S_LOOKUP && acc_q != ACC_RSVD && hit && hit_perm) ||
                     (state == S_FILL && !pfault_q);
  assign touch_way = (state == S_FILL) ? victim : hit_way;

  tlb_lru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
    .clk(clk), .rst_n(rst_n), .set_idx(idx), .set_valid(valid_vec),
    .touch(touch), .touch_way(touch_way), .victim(victim)
  );

  always_comb begin
    clr = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      case (fmode_q)
        FL_ALL:  clr[w] = 1'b1;
        FL_ASID: clr[w] = !ent[fset_q][w].g && ent[fset_q][w].asid == fasid_ext;
        FL_PAGE: clr[w] = ent[fset_q][w].vpn == fvpn_q &&
                          (ent[fset_q][w].g || ent[fset_q][w].asid == fasid_ext);
        default: clr[w] = 1'b0;
      endcase
    end
  end

  assign bus.flush_ready_o    = (state == S_IDLE);
  assign bus.req_ready_o      = (state == S_IDLE) && !bus.flush_valid_i;
  assign bus.resp_valid_o     = (state == S_RESPOND);
  assign bus.ptw_req_valid_o  = (state == S_PTW_REQ);
  assign bus.ptw_resp_ready_o = (state == S_PTW_WAIT);
  assign bus.ptw_vaddr_o      = vaddr_q;
  assign bus.paddr_o          = paddr_q;
  assign bus.hit_o            = hit_q;
  assign bus.fault_o          = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      vaddr_q <= '0; asid_q <= '0; acc_q <= ACC_READ;
      fmode_q <= FL_NOP; fvpn_q <= '0; fasid_q <= '0; fset_q <= '0;
      pte_ppn_q <= '0; pte_flags_q <= '0; pfault_q <= 1'b0;
      paddr_q <= '0; hit_q <= 1'b0; fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.flush_valid_i) begin
            fmode_q <= flush_mode_t'(bus.flush_mode_i);
            fvpn_q  <= bus.flush_vaddr_i[31:PAGE_OFFSET_W];
            fasid_q <= bus.flush_asid_i;
            case (flush_mode_t'(bus.flush_mode_i))
              FL_ALL, FL_ASID: begin fset_q <= '0; state <= S_FLUSH; end
              FL_PAGE: begin
                fset_q <= bus.flush_vaddr_i[PAGE_OFFSET_W +: IDX_W];
                state  <= S_FLUSH;
              end
              default: state <= S_IDLE;
            endcase
          end else if (bus.req_valid_i) begin
            vaddr_q <= bus.vaddr_i;
            asid_q  <= bus.asid_i;
            acc_q   <= access_type_t'(bus.access_type_i);
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (acc_q == ACC_RSVD || (hit && !hit_perm)) begin
            hit_q <= 1'b1; fault_q <= 1'b1; paddr_q <= '0;
            state <= S_RESPOND;
          end else if (hit) begin
            hit_q <= 1'b1; fault_q <= 1'b0;
            paddr_q <= {hit_e.ppn, vaddr_q[PAGE_OFFSET_W-1:0]};
            state <= S_RESPOND;
          end else
            state <= S_PTW_REQ;
        end
        S_PTW_REQ: if (bus.ptw_req_ready_i) state <= S_PTW_WAIT;
        S_PTW_WAIT: if (bus.ptw_resp_valid_i) begin
          pte_ppn_q   <= bus.ptw_pte_i[31:PAGE_OFFSET_W];
          pte_flags_q <= bus.ptw_pte_i[3:0];
          pfault_q    <= bus.ptw_fault_i;
          state       <= S_FILL;
        end
        S_FILL: begin
          hit_q   <= 1'b0;
          fault_q <= pfault_q || !fill_perm;
          paddr_q <= (!pfault_q && fill_perm) ? {pte_ppn_q, vaddr_q[PAGE_OFFSET_W-1:0]} : '0;
          state   <= S_RESPOND;
        end
        S_RESPOND: if (bus.resp_ready_i) state <= S_IDLE;
        S_FLUSH: begin
          if (fmode_q == FL_PAGE || fset_q == IDX_W'(NUM_SETS-1)) state <= S_IDLE;
          else fset_q <= fset_q + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          ent[s][w] <= '0;
    end else if (state == S_FILL && !pfault_q) begin
      ent[idx][victim] <= '{valid: 1'b1, vpn: vpn, ppn: pte_ppn_q, asid: asid_ext,
                            g: pte_flags_q[PTE_G], x: pte_flags_q[PTE_X],
                            w: pte_flags_q[PTE_W], r: pte_flags_q[PTE_R]};
    end else if (state == S_FLUSH) begin
      for (int w = 0; w < NUM_WAYS; w++)
        if (clr[w]) ent[fset_q][w].valid <= 1'b0;
    end
  end

`ifdef TLB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (perf_clr_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) hit_cnt_o <= hit_cnt_o + 1'b1;
      else if (acc_q != ACC_RSVD) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif
endmodule
